mcd212_dram_arbiter: RTL

//  Shares the single DRAM port of the MCD212 between the CPU bus, the two video display

---
 rtl/mcd212_dram_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mcd212_dram_arbiter.sv
// MCD212 DRAM port arbiter: shares one memory-controller port between the CPU bus,
// two video fetch channels and refresh, one access at a time.
module mcd212_dram_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_MAX_PEND = 8,
  parameter int REFRESH_URGENT   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        display_active,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:1] cpu_addr,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid1_req,
  input  logic [21:1] vid1_addr,
  input  logic        vid2_req,
  input  logic [21:1] vid2_addr,
  output logic [15:0] vid_rdata,
  output logic        vid1_ack,
  output logic        vid2_ack,
  output logic        mem_req,
  output logic        mem_refresh,
  output logic        mem_we,
  output logic [21:1] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int TW = $clog2(REFRESH_INTERVAL + 1);
  localparam int PW = $clog2(REFRESH_MAX_PEND + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH, DONE} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_VID1, OWN_VID2, OWN_REF} owner_t;

  state_t        state, state_next;
  owner_t        owner, owner_next;
  logic [TW-1:0] timer;
  logic [PW-1:0] pending;
  logic          rr_vid2;
  logic          tick, refresh_done, urgent, vid_any, vid_pick2, grant;

  assign tick         = (timer == TW'(REFRESH_INTERVAL - 1));
  assign refresh_done = (state == REFRESH) && mem_ack;
  assign urgent       = (pending >= PW'(REFRESH_URGENT));
  assign vid_any      = vid1_req | vid2_req;
  // CH2 wins only if CH1 is idle or the round-robin pointer favours CH2
  assign vid_pick2    = vid2_req & (~vid1_req | rr_vid2);
  assign grant        = (state == IDLE) && (state_next == ACCESS);

  assign mem_req     = (state == ACCESS);
  assign mem_refresh = (state == REFRESH);
  assign cpu_ack     = (state == DONE) && (owner == OWN_CPU);
  assign vid1_ack    = (state == DONE) && (owner == OWN_VID1);
  assign vid2_ack    = (state == DONE) && (owner == OWN_VID2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= OWN_CPU;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (urgent) begin
          state_next = REFRESH;
          owner_next = OWN_REF;
        end else if (display_active && vid_any) begin
          state_next = ACCESS;
          owner_next = vid_pick2 ? OWN_VID2 : OWN_VID1;
        end else if (cpu_req) begin
          state_next = ACCESS;
          owner_next = OWN_CPU;
        end else if (vid_any) begin
          state_next = ACCESS;
          owner_next = vid_pick2 ? OWN_VID2 : OWN_VID1;
        end else if (pending != '0) begin
          state_next = REFRESH;
          owner_next = OWN_REF;
        end
      end
      ACCESS, REFRESH: if (mem_ack) state_next = DONE;
      DONE:            state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
      rr_vid2   <= 1'b0;
    end else begin
      if (grant) begin
        case (owner_next)
          OWN_CPU: begin
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_be    <= cpu_be;
            mem_wdata <= cpu_wdata;
          end
          OWN_VID1, OWN_VID2: begin
            mem_we    <= 1'b0;
            mem_addr  <= (owner_next == OWN_VID2) ? vid2_addr : vid1_addr;
            mem_be    <= 2'b11;
            mem_wdata <= '0;
            rr_vid2   <= (owner_next == OWN_VID1);
          end
          default: ;
        endcase
      end else if ((state == IDLE) && (state_next == REFRESH)) begin
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_be    <= '0;
        mem_wdata <= '0;
      end
      // Writes hand back zero so the owner never sees stale bus data
      if ((state == ACCESS) && mem_ack) begin
        if (owner == OWN_CPU) cpu_rdata <= mem_we ? 16'h0000 : mem_rdata;
        else                  vid_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer   <= '0;
      pending <= '0;
    end else begin
      timer <= tick ? '0 : timer + TW'(1);
      if (tick && !refresh_done) begin
        if (pending != PW'(REFRESH_MAX_PEND)) pending <= pending + PW'(1);
      end else if (!tick && refresh_done && (pending != '0)) begin
        pending <= pending - PW'(1);
      end
    end
  end
endmodule
